// File: rtl/odeme_istemci_pkg.sv
// odeme_pkg: shared widths, FSM state encoding and the saturating top-up
// helper for the turnstile payment requester (odeme_istemci).
package odeme_pkg;

   localparam int UCRET_W    = 8;    // fare width
   localparam int BAKIYE_W   = 9;    // balance width
   localparam int BAKIYE_MAX = 511;  // balance saturation ceiling
   localparam int SAYAC_W    = 8;    // shared down-counter width

   localparam logic [2:0] S_BOSTA = 3'd0;
   localparam logic [2:0] S_ISTEK = 3'd1;
   localparam logic [2:0] S_BEKLE = 3'd2;
   localparam logic [2:0] S_GECIS = 3'd3;
   localparam logic [2:0] S_RED   = 3'd4;

   typedef enum logic [2:0] {
      BOSTA = S_BOSTA,
      ISTEK = S_ISTEK,
      BEKLE = S_BEKLE,
      GECIS = S_GECIS,
      RED   = S_RED
   } durum_t;

   // Top-up add, clamped at BAKIYE_MAX instead of wrapping.
   function automatic logic [BAKIYE_W-1:0] doygun_topla(input logic [BAKIYE_W-1:0] a,
                                                        input logic [UCRET_W-1:0]  b);
      logic [BAKIYE_W:0] t;
      t = {1'b0, a} + {2'b00, b};
      if (t > (BAKIYE_W+1)'(BAKIYE_MAX)) return BAKIYE_W'(BAKIYE_MAX);
      return t[BAKIYE_W-1:0];
   endfunction

endpackage

// File: rtl/odeme_istemci_if.sv
// odeme_istemci_if: request/reply bundle between the card-side requester and
// the payment unit.
//  basla    requester -> unit  one-cycle request strobe
//  ucret    requester -> unit  fare
//  bakiye   requester -> unit  card balance at tap time
//  bitti    unit -> requester  reply strobe
//  onay     unit -> requester  approval, valid with bitti
//  k_bakiye unit -> requester  remaining balance, valid with bitti
interface odeme_istemci_if;
   import odeme_pkg::*;

   logic                basla;
   logic [UCRET_W-1:0]  ucret;
   logic [BAKIYE_W-1:0] bakiye;
   logic                bitti;
   logic                onay;
   logic [BAKIYE_W-1:0] k_bakiye;

   modport master (output basla, ucret, bakiye, input bitti, onay, k_bakiye);
   modport slave  (input basla, ucret, bakiye, output bitti, onay, k_bakiye);
endinterface

// File: rtl/odeme_istemci_geri_sayac.sv
// geri_sayac: loadable down-counter with a zero flag. One instance is time-
// shared between the reply timeout and the gate-open duration, since those
// two phases never overlap.
//  saat/reset  clock, async active-low reset (count clears to 0)
//  yukle_i     load deger_i (wins over azalt_i)
//  azalt_i     decrement, holds at zero
//  sifir_o     count is zero
module geri_sayac #(
   parameter int W = 8
) (
   input  logic         saat,
   input  logic         reset,
   input  logic         yukle_i,
   input  logic         azalt_i,
   input  logic [W-1:0] deger_i,
   output logic         sifir_o
);
   logic [W-1:0] say_q, say_d;

   always_comb begin
      say_d = say_q;
      if (yukle_i)                    say_d = deger_i;
      else if (azalt_i && say_q != '0) say_d = say_q - W'(1);
   end

   always_ff @(posedge saat or negedge reset) begin
      if (!reset) say_q <= '0;
      else        say_q <= say_d;
   end

   assign sifir_o = (say_q == '0);
endmodule

// File: rtl/odeme_istemci.sv
// odeme_istemci: requester side of the turnstile payment handshake.
// Holds the card balance, turns a tap into a one-cycle basla request and
// waits for the payment unit's reply, then opens the gate or rejects.
//  saat, reset            clock, async active-low reset
//  kart_okut, ucret_sec   card tap and fare selector
//  yukle, yukleme         top-up request and amount (accepted only when idle)
//  bus (master)           basla/ucret/bakiye out, bitti/onay/k_bakiye in
//  kart_bakiye            card balance register
//  gecis, red             gate open (GECIS_SURESI cycles) / reject pulse
//  zaman_asimi            timeout pulse, coincides with red
//  tutarsiz               sticky reply-balance mismatch flag
//  mesgul                 any state other than BOSTA
module odeme_istemci
   import odeme_pkg::*;
#(
   parameter logic [UCRET_W-1:0]  UCRET_0          = 8'd25,
   parameter logic [UCRET_W-1:0]  UCRET_1          = 8'd40,
   parameter logic [UCRET_W-1:0]  UCRET_2          = 8'd60,
   parameter logic [UCRET_W-1:0]  UCRET_3          = 8'd100,
   parameter int                  ZAMAN_ASIMI      = 15,
   parameter int                  GECIS_SURESI     = 8,
   parameter logic [BAKIYE_W-1:0] BASLANGIC_BAKIYE = 9'd0
) (
   input  logic                saat,
   input  logic                reset,
   input  logic                kart_okut,
   input  logic [1:0]          ucret_sec,
   input  logic                yukle,
   input  logic [UCRET_W-1:0]  yukleme,
   odeme_istemci_if.master     bus,
   output logic [BAKIYE_W-1:0] kart_bakiye,
   output logic                gecis,
   output logic                red,
   output logic                zaman_asimi,
   output logic                tutarsiz,
   output logic                mesgul
);
   // Counter is reloaded with N-1 and the phase ends on the cycle it is seen
   // at zero, giving exactly N cycles in BEKLE / GECIS.
   localparam logic [SAYAC_W-1:0] ZA_YUK = SAYAC_W'(ZAMAN_ASIMI - 1);
   localparam logic [SAYAC_W-1:0] GS_YUK = SAYAC_W'(GECIS_SURESI - 1);

   durum_t              durum_q, durum_d;
   logic [UCRET_W-1:0]  ucret_q, ucret_d, secili_ucret;
   logic [BAKIYE_W-1:0] bakiye_q, bakiye_d;
   logic [BAKIYE_W-1:0] kart_q, kart_d;
   logic                tut_q, tut_d;
   logic                za_q, za_d;
   logic                basla_q, gecis_q, red_q, mesgul_q;
   logic                say_yukle, say_azalt, say_sifir;
   logic [SAYAC_W-1:0]  say_deger;

   geri_sayac #(.W(SAYAC_W)) u_sayac (
      .saat    (saat),
      .reset   (reset),
      .yukle_i (say_yukle),
      .azalt_i (say_azalt),
      .deger_i (say_deger),
      .sifir_o (say_sifir)
   );

   always_comb begin
      secili_ucret = UCRET_0;
      case (ucret_sec)
         2'd0:    secili_ucret = UCRET_0;
         2'd1:    secili_ucret = UCRET_1;
         2'd2:    secili_ucret = UCRET_2;
         default: secili_ucret = UCRET_3;
      endcase
   end

   always_comb begin
      durum_d   = durum_q;
      ucret_d   = ucret_q;
      bakiye_d  = bakiye_q;
      kart_d    = kart_q;
      tut_d     = tut_q;
      za_d      = 1'b0;
      say_yukle = 1'b0;
      say_azalt = 1'b0;
      say_deger = '0;
      case (durum_q)
         BOSTA: begin
            // Top-up has priority; a simultaneous tap is dropped.
            if (yukle) kart_d = doygun_topla(kart_q, yukleme);
            else if (kart_okut) begin
               ucret_d  = secili_ucret;
               bakiye_d = kart_q;
               durum_d  = ISTEK;
            end
         end
         ISTEK: begin
            durum_d   = BEKLE;
            say_yukle = 1'b1;
            say_deger = ZA_YUK;
         end
         BEKLE: begin
            if (bus.bitti) begin
               // On approval the unit must report exactly bakiye-ucret.
               if (bus.onay && bus.k_bakiye == bakiye_q - {1'b0, ucret_q}) begin
                  kart_d    = bus.k_bakiye;
                  durum_d   = GECIS;
                  say_yukle = 1'b1;
                  say_deger = GS_YUK;
               end else begin
                  if (bus.onay) tut_d = 1'b1;
                  durum_d = RED;
               end
            end else if (say_sifir) begin
               za_d    = 1'b1;
               durum_d = RED;
            end else begin
               say_azalt = 1'b1;
            end
         end
         GECIS: begin
            if (say_sifir) durum_d = BOSTA;
            else           say_azalt = 1'b1;
         end
         RED:     durum_d = BOSTA;
         default: durum_d = BOSTA;
      endcase
   end

   // Status outputs are decoded from the next state so they line up with it.
   always_ff @(posedge saat or negedge reset) begin
      if (!reset) begin
         durum_q  <= BOSTA;
         ucret_q  <= '0;
         bakiye_q <= '0;
         kart_q   <= BASLANGIC_BAKIYE;
         tut_q    <= 1'b0;
         za_q     <= 1'b0;
         basla_q  <= 1'b0;
         gecis_q  <= 1'b0;
         red_q    <= 1'b0;
         mesgul_q <= 1'b0;
      end else begin
         durum_q  <= durum_d;
         ucret_q  <= ucret_d;
         bakiye_q <= bakiye_d;
         kart_q   <= kart_d;
         tut_q    <= tut_d;
         za_q     <= za_d;
         basla_q  <= (durum_d == ISTEK);
         gecis_q  <= (durum_d == GECIS);
         red_q    <= (durum_d == RED);
         mesgul_q <= (durum_d != BOSTA);
      end
   end

   assign bus.basla   = basla_q;
   assign bus.ucret   = ucret_q;
   assign bus.bakiye  = bakiye_q;
   assign kart_bakiye = kart_q;
   assign gecis       = gecis_q;
   assign red         = red_q;
   assign zaman_asimi = za_q;
   assign tutarsiz    = tut_q;
   assign mesgul      = mesgul_q;
endmodule

// File: tb/tb_odeme_istemci.sv
module tb_odeme_istemci;
   localparam int ZA  = 15;
   localparam int GS  = 8;
   localparam int BAS = 0;

   logic       saat = 1'b0;
   logic       reset;
   logic       kart_okut, yukle;
   logic [1:0] ucret_sec;
   logic [7:0] yukleme;
   logic [8:0] kart_bakiye;
   logic       gecis, red, zaman_asimi, tutarsiz, mesgul;

   odeme_istemci_if bus();

   odeme_istemci #(
      .ZAMAN_ASIMI(ZA), .GECIS_SURESI(GS), .BASLANGIC_BAKIYE(9'(BAS))
   ) dut (
      .saat(saat), .reset(reset), .kart_okut(kart_okut), .ucret_sec(ucret_sec),
      .yukle(yukle), .yukleme(yukleme), .bus(bus), .kart_bakiye(kart_bakiye),
      .gecis(gecis), .red(red), .zaman_asimi(zaman_asimi), .tutarsiz(tutarsiz),
      .mesgul(mesgul)
   );

   always #5 saat = ~saat;

   int npass = 0, ntot = 0;
   bit chk_on = 0;

   task automatic chk(input string nm, input int act, input int exp);
      ntot++;
      if (act == exp) npass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   // ---------------- behavioural model (timeline of expected events) -------
   // cyc numbers the interval after each rising edge. Each transaction is
   // recorded as the interval numbers where its visible effects occur.
   int cyc = 0;
   int bal, m_ucret, m_bakiye;
   bit m_tut, waiting;
   int basla_c, red_c, to_c, g_lo, g_hi, busy_lo, busy_hi, deadline;

   function automatic int fare(input int s);
      case (s)
         0: return 25;
         1: return 40;
         2: return 60;
         default: return 100;
      endcase
   endfunction

   initial forever begin
      @(posedge saat or negedge reset);
      if (!reset) begin
         bal = BAS; m_ucret = 0; m_bakiye = 0; m_tut = 0; waiting = 0;
         basla_c = -1; red_c = -1; to_c = -1; g_lo = -1; g_hi = -2;
         busy_lo = -1; busy_hi = -2; deadline = -1;
      end else begin
         cyc++;
         if (waiting) begin
            // reply accepted only once the request strobe has gone by
            if (cyc >= basla_c + 2 && bus.bitti) begin
               waiting = 0;
               if (bus.onay && int'(bus.k_bakiye) == m_bakiye - m_ucret) begin
                  bal = bus.k_bakiye; g_lo = cyc; g_hi = cyc + GS - 1; busy_hi = g_hi;
               end else begin
                  if (bus.onay) m_tut = 1;
                  red_c = cyc; busy_hi = cyc;
               end
            end else if (cyc == deadline) begin
               waiting = 0; to_c = cyc; red_c = cyc; busy_hi = cyc;
            end
         end else if (cyc - 1 > busy_hi) begin
            if (yukle) bal = (bal + yukleme > 511) ? 511 : bal + yukleme;
            else if (kart_okut) begin
               m_ucret = fare(ucret_sec); m_bakiye = bal;
               basla_c = cyc; busy_lo = cyc; busy_hi = 1 << 30;
               waiting = 1; deadline = cyc + ZA + 1;
            end
         end
      end
   end

   // ---------------- per-cycle compare ------------------------------------
   always @(negedge saat) begin
      if (reset && chk_on) begin
         chk("basla",       bus.basla,    int'(cyc == basla_c));
         chk("ucret",       bus.ucret,    m_ucret);
         chk("bakiye",      bus.bakiye,   m_bakiye);
         chk("kart_bakiye", kart_bakiye,  bal);
         chk("gecis",       gecis,        int'(cyc >= g_lo && cyc <= g_hi));
         chk("red",         red,          int'(cyc == red_c));
         chk("zaman_asimi", zaman_asimi,  int'(cyc == to_c));
         chk("tutarsiz",    tutarsiz,     int'(m_tut));
         chk("mesgul",      mesgul,       int'(cyc >= busy_lo && cyc <= busy_hi));
      end
   end

   // ---------------- zero-wait payment unit --------------------------------
   bit       rsp_on = 0, rsp_onay = 0;
   int       rsp_gec = 0;
   int       rsp_kb = 0;

   initial begin
      bus.bitti = 0; bus.onay = 0; bus.k_bakiye = '0;
      forever begin
         @(negedge saat);
         if (reset && bus.basla && rsp_on) begin
            repeat (rsp_gec) @(posedge saat);
            @(posedge saat); #1;
            bus.bitti = 1; bus.onay = rsp_onay; bus.k_bakiye = 9'(rsp_kb);
            @(posedge saat); #1;
            bus.bitti = 0; bus.onay = 0; bus.k_bakiye = '0;
         end
      end
   end

   // ---------------- stimulus helpers (called at a falling edge) -----------
   task automatic tap(input logic [1:0] s);
      kart_okut = 1; ucret_sec = s;
      @(negedge saat);
      kart_okut = 0;
   endtask

   task automatic topup(input int a);
      yukle = 1; yukleme = 8'(a);
      @(negedge saat);
      yukle = 0;
   endtask

   task automatic do_reset();
      @(negedge saat); reset = 0;
      @(negedge saat); reset = 1;
   endtask

   task automatic wait_idle(input string nm);
      for (int i = 0; i < 60 && mesgul; i++) @(negedge saat);
      chk(nm, mesgul, 0);
   endtask

   task automatic wait_basla(input string nm);
      for (int i = 0; i < 10 && !bus.basla; i++) @(negedge saat);
      chk(nm, bus.basla, 1);
   endtask

   task automatic wait_red(input string nm);
      for (int i = 0; i < 40 && !red; i++) @(negedge saat);
      chk(nm, red, 1);
   endtask

   initial begin
      int n;
      bit seen;
      reset = 1; kart_okut = 0; ucret_sec = 0; yukle = 0; yukleme = 0;
      #1 reset = 0;
      @(negedge saat); @(negedge saat);
      chk("rst_kart", kart_bakiye, BAS);
      chk("rst_mesgul", mesgul, 0);
      chk("rst_basla", bus.basla, 0);
      reset = 1; chk_on = 1;
      @(negedge saat);

      // 1: approve path
      topup(100);
      chk("t1_topup", kart_bakiye, 100);
      rsp_on = 1; rsp_onay = 1; rsp_kb = 60; rsp_gec = 0;
      tap(2'd1);
      wait_basla("t1_basla");
      chk("t1_ucret", bus.ucret, 40);
      chk("t1_bakiye", bus.bakiye, 100);
      for (int i = 0; i < 10 && !gecis; i++) @(negedge saat);
      n = 0;
      while (gecis && n < 20) begin n++; @(negedge saat); end
      chk("t1_gecis_len", n, 8);
      chk("t1_mesgul_after", mesgul, 0);
      chk("t1_kart", kart_bakiye, 60);

      // 2: approve then reject
      do_reset();
      @(negedge saat);
      topup(30);
      rsp_onay = 1; rsp_kb = 5;
      tap(2'd0);
      wait_idle("t2_idle1");
      chk("t2_kart1", kart_bakiye, 5);
      rsp_onay = 0; rsp_kb = 0;
      tap(2'd1);
      wait_red("t2_red");
      @(negedge saat);
      chk("t2_red_pulse", red, 0);
      chk("t2_kart2", kart_bakiye, 5);

      // 3: timeout, late reply ignored
      wait_idle("t3_idle");
      rsp_onay = 1; rsp_kb = 0; rsp_gec = 20;
      tap(2'd0);
      wait_basla("t3_basla");
      n = 0;
      while (!zaman_asimi && n < 40) begin n++; @(negedge saat); end
      chk("t3_za_delay", n, 16);
      chk("t3_red_with_za", red, 1);
      repeat (12) @(negedge saat);
      chk("t3_kart", kart_bakiye, 5);
      chk("t3_idle_after_late", mesgul, 0);
      rsp_gec = 0;

      // 4: saturation, top-up beats tap
      do_reset();
      @(negedge saat);
      topup(250); topup(250);
      chk("t4_500", kart_bakiye, 500);
      topup(50);
      chk("t4_sat", kart_bakiye, 511);
      yukle = 1; yukleme = 8'd10; kart_okut = 1; ucret_sec = 2'd0;
      @(negedge saat);
      yukle = 0; kart_okut = 0;
      seen = 0;
      for (int i = 0; i < 4; i++) begin seen |= bus.basla | mesgul; @(negedge saat); end
      chk("t4_no_basla", seen, 0);
      chk("t4_kart", kart_bakiye, 511);

      // 5: mismatch, sticky tutarsiz
      do_reset();
      @(negedge saat);
      topup(100);
      rsp_onay = 1; rsp_kb = 99;
      tap(2'd0);
      wait_red("t5_red");
      @(negedge saat);
      chk("t5_tutarsiz", tutarsiz, 1);
      chk("t5_kart", kart_bakiye, 100);
      wait_idle("t5_idle");
      rsp_kb = 75;
      tap(2'd0);
      wait_idle("t5_idle2");
      chk("t5_kart2", kart_bakiye, 75);
      chk("t5_sticky", tutarsiz, 1);

      // 6: async reset in BEKLE
      rsp_on = 0;
      tap(2'd3);
      repeat (5) @(negedge saat);
      chk("t6_mesgul_pre", mesgul, 1);
      #3 reset = 0;
      #1;
      chk("t6_mesgul", mesgul, 0);
      chk("t6_kart", kart_bakiye, BAS);
      chk("t6_ucret", bus.ucret, 0);
      chk("t6_bakiye", bus.bakiye, 0);
      chk("t6_tutarsiz", tutarsiz, 0);
      chk("t6_basla", int'(bus.basla | gecis | red | zaman_asimi), 0);
      @(negedge saat);
      reset = 1;
      repeat (3) @(negedge saat);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
